// File: rtl/vout_pkg.sv
// Shared timing constants, FSM state encoding and helpers for the video output
// raster timing generator.
package vout_pkg;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FP      = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BP      = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FP      = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BP      = 33;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_t;

    function automatic int calc_total(input int visible, input int fp,
                                      input int sync, input int bp);
        return visible + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vout_timing_axis.sv
// One raster axis: a wrapping position counter plus decode of the visible
// and sync regions (order: visible, front porch, sync, back porch).
module vout_timing_axis
    import vout_pkg::*;
#(
    parameter int VISIBLE   = DEF_H_VISIBLE,
    parameter int FP        = DEF_H_FP,
    parameter int SYNC      = DEF_H_SYNC,
    parameter int BP        = DEF_H_BP,
    parameter int CNT_WIDTH = 12
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clear,
    input  logic                 advance,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 wrap,
    output logic                 active,
    output logic                 sync_zone
);

    localparam int TOTAL = calc_total(VISIBLE, FP, SYNC, BP);

    localparam logic [CNT_WIDTH-1:0] LAST       = CNT_WIDTH'(TOTAL - 1);
    localparam logic [CNT_WIDTH-1:0] VIS_END    = CNT_WIDTH'(VISIBLE);
    localparam logic [CNT_WIDTH-1:0] SYNC_START = CNT_WIDTH'(VISIBLE + FP);
    localparam logic [CNT_WIDTH-1:0] SYNC_END   = CNT_WIDTH'(VISIBLE + FP + SYNC);

    assign wrap      = (count == LAST);
    assign active    = (count < VIS_END);
    assign sync_zone = (count >= SYNC_START) && (count < SYNC_END);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (advance) begin
            count <= wrap ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/vout_timing_gen.sv
// Programmable raster timing generator feeding the AXI4-Stream video output
// stage; starts and stops only on frame boundaries.
module vout_timing_gen
    import vout_pkg::*;
#(
    parameter int   H_VISIBLE = DEF_H_VISIBLE,
    parameter int   H_FP      = DEF_H_FP,
    parameter int   H_SYNC    = DEF_H_SYNC,
    parameter int   H_BP      = DEF_H_BP,
    parameter int   V_VISIBLE = DEF_V_VISIBLE,
    parameter int   V_FP      = DEF_V_FP,
    parameter int   V_SYNC    = DEF_V_SYNC,
    parameter int   V_BP      = DEF_V_BP,
    parameter logic HSYNC_POL = 1'b0,
    parameter logic VSYNC_POL = 1'b0,
    parameter int   CNT_WIDTH = 12
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    output logic                 busy,
    output logic                 out_vsync,
    output logic                 out_hsync,
    output logic                 out_de,
    output logic [3:0]           out_ctl,
    output logic                 out_frame_start,
    output logic                 out_line_start,
    output logic [CNT_WIDTH-1:0] out_x,
    output logic [CNT_WIDTH-1:0] out_y
);

    state_t state;
    state_t state_next;

    logic                 running;
    logic                 last_pixel;
    logic [CNT_WIDTH-1:0] h_count;
    logic [CNT_WIDTH-1:0] v_count;
    logic                 h_wrap;
    logic                 v_wrap;
    logic                 h_active;
    logic                 v_active;
    logic                 h_sync;
    logic                 v_sync;

    assign running    = (state != ST_IDLE);
    assign last_pixel = h_wrap && v_wrap;
    assign out_ctl    = 4'd0;

    // Counters sit at (0,0) in IDLE so the first RUN cycle presents pixel (0,0).
    vout_timing_axis #(
        .VISIBLE  (H_VISIBLE),
        .FP       (H_FP),
        .SYNC     (H_SYNC),
        .BP       (H_BP),
        .CNT_WIDTH(CNT_WIDTH)
    ) u_h_axis (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (!running),
        .advance  (1'b1),
        .count    (h_count),
        .wrap     (h_wrap),
        .active   (h_active),
        .sync_zone(h_sync)
    );

    vout_timing_axis #(
        .VISIBLE  (V_VISIBLE),
        .FP       (V_FP),
        .SYNC     (V_SYNC),
        .BP       (V_BP),
        .CNT_WIDTH(CNT_WIDTH)
    ) u_v_axis (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (!running),
        .advance  (h_wrap),
        .count    (v_count),
        .wrap     (v_wrap),
        .active   (v_active),
        .sync_zone(v_sync)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // STOP keeps counting so the frame in flight always completes.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (enable) state_next = ST_RUN;
            ST_RUN:  if (!enable) state_next = ST_STOP;
            ST_STOP: begin
                if (enable) begin
                    state_next = ST_RUN;
                end else if (last_pixel) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy            <= 1'b0;
            out_de          <= 1'b0;
            out_hsync       <= ~HSYNC_POL;
            out_vsync       <= ~VSYNC_POL;
            out_frame_start <= 1'b0;
            out_line_start  <= 1'b0;
            out_x           <= '0;
            out_y           <= '0;
        end else if (!running) begin
            busy            <= 1'b0;
            out_de          <= 1'b0;
            out_hsync       <= ~HSYNC_POL;
            out_vsync       <= ~VSYNC_POL;
            out_frame_start <= 1'b0;
            out_line_start  <= 1'b0;
            out_x           <= '0;
            out_y           <= '0;
        end else begin
            busy            <= 1'b1;
            out_de          <= h_active && v_active;
            out_hsync       <= h_sync ? HSYNC_POL : ~HSYNC_POL;
            out_vsync       <= v_sync ? VSYNC_POL : ~VSYNC_POL;
            out_frame_start <= (h_count == '0) && (v_count == '0);
            out_line_start  <= (h_count == '0);
            out_x           <= h_count;
            out_y           <= v_count;
        end
    end

endmodule

// File: tb/tb_vout_timing_gen.sv
// Bench for vout_timing_gen on a tiny 14x7 raster: per-cycle scoreboard
// against a pixel-index model plus table-driven segment totals.
module tb_vout_timing_gen;

    localparam int HT    = 14;
    localparam int FRAME = 98;
    localparam int CW    = 12;

    typedef struct packed {
        logic          busy;
        logic          vsync;
        logic          hsync;
        logic          de;
        logic          fs;
        logic          ls;
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic [3:0]    ctl;
    } obs_t;

    typedef struct {
        logic en;
        int   cycles;
        int   de_cnt;
        int   fs_cnt;
        int   busy_cnt;
    } seg_t;

    localparam obs_t RESET_OBS = '{busy: 1'b0, vsync: 1'b1, hsync: 1'b1, de: 1'b0,
                                   fs: 1'b0, ls: 1'b0, x: '0, y: '0, ctl: 4'd0};

    logic          clk = 1'b0;
    logic          reset_n;
    logic          enable;
    logic          busy;
    logic          out_vsync;
    logic          out_hsync;
    logic          out_de;
    logic [3:0]    out_ctl;
    logic          out_frame_start;
    logic          out_line_start;
    logic [CW-1:0] out_x;
    logic [CW-1:0] out_y;

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   m_mode;
    int   m_p;
    logic prev_vs;

    always #5 clk = ~clk;

    vout_timing_gen #(
        .H_VISIBLE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_VISIBLE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CNT_WIDTH(CW)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .enable         (enable),
        .busy           (busy),
        .out_vsync      (out_vsync),
        .out_hsync      (out_hsync),
        .out_de         (out_de),
        .out_ctl        (out_ctl),
        .out_frame_start(out_frame_start),
        .out_line_start (out_line_start),
        .out_x          (out_x),
        .out_y          (out_y)
    );

    function automatic obs_t actual();
        return {busy, out_vsync, out_hsync, out_de, out_frame_start,
                out_line_start, out_x, out_y, out_ctl};
    endfunction

    // Mode 0/1/2 = idle/run/stop; m_p is the flat pixel index within a frame.
    function automatic obs_t model_out();
        obs_t o;
        int   x;
        int   y;
        o = RESET_OBS;
        if (m_mode != 0) begin
            x       = m_p % HT;
            y       = m_p / HT;
            o.busy  = 1'b1;
            o.de    = (x < 8) && (y < 4);
            o.hsync = !((x >= 10) && (x < 12));
            o.vsync = (y != 5);
            o.fs    = (m_p == 0);
            o.ls    = (x == 0);
            o.x     = CW'(x);
            o.y     = CW'(y);
        end
        return o;
    endfunction

    task automatic model_advance(input logic en);
        case (m_mode)
            0: if (en) begin m_mode = 1; m_p = 0; end
            1: begin m_p = (m_p + 1) % FRAME; if (!en) m_mode = 2; end
            default: begin
                if (en) begin
                    m_mode = 1;
                    m_p    = (m_p + 1) % FRAME;
                end else if (m_p == FRAME - 1) begin
                    m_mode = 0;
                    m_p    = 0;
                end else begin
                    m_p = m_p + 1;
                end
            end
        endcase
    endtask

    task automatic check_obs(input string name, input obs_t act, input obs_t req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual busy/vs/hs/de/fs/ls=%b%b%b%b%b%b x=%0d y=%0d ctl=%0d required busy/vs/hs/de/fs/ls=%b%b%b%b%b%b x=%0d y=%0d ctl=%0d",
                     name, act.busy, act.vsync, act.hsync, act.de, act.fs, act.ls,
                     act.x, act.y, act.ctl, req.busy, req.vsync, req.hsync, req.de,
                     req.fs, req.ls, req.x, req.y, req.ctl);
        end
    endtask

    task automatic check_int(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic apply_stimulus(input logic en, output obs_t got);
        obs_t req;
        enable = en;
        exp_q.push_back(model_out());
        model_advance(en);
        @(posedge clk);
        #1;
        got = actual();
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard_empty actual=0 required=1");
        end else begin
            req = exp_q.pop_front();
            check_obs("pixel", got, req);
        end
        if (got.vsync !== prev_vs) begin
            check_int("vsync_at_line_start", int'(got.ls), 1);
        end
        prev_vs = got.vsync;
    endtask

    task automatic check_output(input seg_t s, input int idx);
        obs_t got;
        int   de_n   = 0;
        int   fs_n   = 0;
        int   busy_n = 0;
        for (int c = 0; c < s.cycles; c++) begin
            apply_stimulus(s.en, got);
            de_n   += int'(got.de);
            fs_n   += int'(got.fs);
            busy_n += int'(got.busy);
        end
        check_int($sformatf("seg%0d de_count", idx), de_n, s.de_cnt);
        check_int($sformatf("seg%0d frame_starts", idx), fs_n, s.fs_cnt);
        check_int($sformatf("seg%0d busy_cycles", idx), busy_n, s.busy_cnt);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        seg_t segs[12];
        seg_t restart;
        obs_t got;

        // Continuous run, a stop/restart without a gap, a restart on the
        // last STOP pixel, then a single-cycle enable producing one frame.
        segs = '{
            '{1'b1,  99, 32, 1, 98},
            '{1'b1,  98, 32, 1, 98},
            '{1'b1,  28, 16, 1, 28},
            '{1'b0,  42, 16, 0, 42},
            '{1'b1,  28,  0, 0, 28},
            '{1'b1,  98, 32, 1, 98},
            '{1'b0,  97, 32, 1, 97},
            '{1'b1,   1,  0, 0,  1},
            '{1'b1,   1,  1, 1,  1},
            '{1'b0,  98, 31, 0, 97},
            '{1'b1,   1,  0, 0,  0},
            '{1'b0, 105, 32, 1, 98}
        };
        restart = '{1'b1, 99, 32, 1, 98};

        reset_n = 1'b0;
        enable  = 1'b0;
        m_mode  = 0;
        m_p     = 0;
        prev_vs = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_obs("reset_state", actual(), RESET_OBS);
        reset_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            check_output(segs[i], i);
        end

        // Reset mid-frame with the counters at h=3, v=1.
        for (int i = 0; i < 18; i++) begin
            apply_stimulus(1'b1, got);
        end
        check_int("pre_reset_pixel", m_p, 17);
        #2;
        reset_n = 1'b0;
        #1;
        check_obs("async_reset", actual(), RESET_OBS);
        exp_q.delete();
        m_mode  = 0;
        m_p     = 0;
        prev_vs = 1'b1;
        #1;
        reset_n = 1'b1;
        check_output(restart, 12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
